// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows
// combine their pair max with the buffered value to emit one pooled pixel.
// Optional build macro MAXPOOL_RELU_EN clamps pooled outputs at zero.
module maxpool2x2_stream #(
    parameter int DATA_W    = 20,
    parameter int MAX_WIDTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        width,
    input  logic [7:0]        height,
    input  logic [DATA_W-1:0] in_pixel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EVEN_ROW = 2'd1;
    localparam logic [1:0] ODD_ROW  = 2'd2;

    localparam int LB_DEPTH = MAX_WIDTH / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [1:0]               state_q;
    logic [7:0]               we_q, he_q, col_q, row_q;
    logic signed [DATA_W-1:0] pair_q, out_q;
    logic                     out_valid_q, done_q, last_q;
    logic signed [DATA_W-1:0] linebuf [LB_DEPTH];

    logic [7:0]               w_even, w_eff, h_eff;
    logic                     xfer, col_last, row_last, load, lb_wr;
    logic [LB_AW-1:0]         lb_idx;
    logic signed [DATA_W-1:0] pix, pair_max, lb_rd, pool_max, pool_out;

    // Effective frame size: even dimensions, width clipped to the line buffer.
    always_comb begin
        w_even = width & 8'hFE;
        h_eff  = height & 8'hFE;
        w_eff  = ({1'b0, w_even} > 9'(MAX_WIDTH)) ? 8'(MAX_WIDTH) : w_even;
    end

    // Datapath: pair max, line-buffer read, window max and optional clamp.
    always_comb begin
        pix      = in_pixel;
        in_ready = (state_q != IDLE) && !(out_valid_q && !out_ready);
        xfer     = in_valid && in_ready;
        col_last = (col_q == we_q - 8'd1);
        row_last = (row_q == he_q - 8'd1);
        lb_idx   = col_q[LB_AW:1];
        pair_max = (pix > pair_q) ? pix : pair_q;
        lb_rd    = linebuf[lb_idx];
        pool_max = (pair_max > lb_rd) ? pair_max : lb_rd;
`ifdef MAXPOOL_RELU_EN
        pool_out = pool_max[DATA_W-1] ? '0 : pool_max;
`else
        pool_out = pool_max;
`endif
        load     = xfer && (state_q == ODD_ROW) && col_q[0];
        lb_wr    = xfer && (state_q == EVEN_ROW) && col_q[0];
    end

    // Frame sequencing, counters, pair register, output register and done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= '0;
            he_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (w_eff != 8'd0) && (h_eff != 8'd0)) begin
                        we_q    <= w_eff;
                        he_q    <= h_eff;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= EVEN_ROW;
                    end
                end
                EVEN_ROW, ODD_ROW: begin
                    if (xfer) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + 8'd1;
                            if (state_q == EVEN_ROW) begin
                                state_q <= ODD_ROW;
                            end else if (row_last) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= EVEN_ROW;
                            end
                        end else begin
                            col_q <= col_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (xfer && !col_q[0]) begin
                pair_q <= pix;
            end

            // Done follows acceptance of the frame's final result.
            if (out_valid_q && out_ready && last_q) begin
                done_q <= 1'b1;
                last_q <= 1'b0;
            end

            if (load) begin
                out_q       <= pool_out;
                out_valid_q <= 1'b1;
                if (row_last && col_last) begin
                    last_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Line buffer holds even-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (rst && lb_wr) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    assign out_pixel = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: expected pooled pixels are queued
// by the stimulus thread and checked by a monitor on every accepted output.
module tb_maxpool2x2_stream;

    localparam int DATA_W = 20;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [7:0]               width, height;
    logic signed [DATA_W-1:0] in_pixel;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_pixel;
    logic                     out_valid;
    logic                     out_ready;
    logic                     done;

    int total;
    int bad;
    int done_cnt;
    int exp_q[$];

    int f4[16] = '{14, 1, 0, 100, 0, -1, 0, -100, 0, 0, 0, 0, 1, 2, 0, 1};

    maxpool2x2_stream #(
        .DATA_W(DATA_W),
        .MAX_WIDTH(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .width(width),
        .height(height),
        .in_pixel(in_pixel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_pixel(out_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %0d expected none", out_pixel);
                end else begin
                    check("out_pixel", int'(out_pixel), exp_q.pop_front());
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send_pixel(input int v);
        bit ok;
        ok = 1'b0;
        in_pixel = DATA_W'(v);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int w, input int h);
        width  = 8'(w);
        height = 8'(h);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic send_f4();
        for (int i = 0; i < 16; i++) send_pixel(f4[i]);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic push_f4_exp();
        exp_q.push_back(14);
        exp_q.push_back(100);
        exp_q.push_back(2);
        exp_q.push_back(1);
    endtask

    initial begin
        int d0;
        bit seen;
        total     = 0;
        bad       = 0;
        done_cnt  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        width     = '0;
        height    = '0;
        in_pixel  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 4x4 frame, free-flowing output
        d0 = done_cnt;
        push_f4_exp();
        do_start(4, 4);
        send_f4();
        wait_drain("f4_drain");
        check("f4_done", done_cnt - d0, 1);
        check("f4_idle_in_ready", int'(in_ready), 0);

        // Same frame with output stalled at the first result
        d0 = done_cnt;
        out_ready = 1'b0;
        push_f4_exp();
        do_start(4, 4);
        fork
            send_f4();
            begin
                seen = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("stall_seen_valid", int'(seen), 1);
                for (int k = 0; k < 5; k++) begin
                    check("stall_out_pixel", int'(out_pixel), 14);
                    check("stall_in_ready", int'(in_ready), 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain("stall_drain");
        check("stall_done", done_cnt - d0, 1);

        // Most negative value, 2x2 frame
        d0 = done_cnt;
`ifdef MAXPOOL_RELU_EN
        exp_q.push_back(0);
`else
        exp_q.push_back(-524288);
`endif
        do_start(2, 2);
        for (int i = 0; i < 4; i++) send_pixel(-524288);
        wait_drain("neg_drain");
        check("neg_done", done_cnt - d0, 1);

        // Odd dimensions 5x3 behave as 4x2
        d0 = done_cnt;
        exp_q.push_back(5);
        exp_q.push_back(7);
        do_start(5, 3);
        send_pixel(1);
        send_pixel(2);
        send_pixel(3);
        send_pixel(4);
        send_pixel(5);
        send_pixel(-6);
        send_pixel(7);
        send_pixel(-8);
        check("odd_idle_in_ready", int'(in_ready), 0);
        wait_drain("odd_drain");
        check("odd_done", done_cnt - d0, 1);

        // Zero width never starts
        d0 = done_cnt;
        do_start(0, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("w0_in_ready", int'(in_ready), 0);
        end
        check("w0_no_done", done_cnt - d0, 0);

        // Reset mid-frame, then a fresh 2x2 frame
        d0 = done_cnt;
        exp_q.push_back(6);
        do_start(4, 4);
        for (int i = 1; i <= 6; i++) send_pixel(i);
        repeat (3) @(posedge clk);
        #1;
        check("mid_drain", exp_q.size(), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_no_done", done_cnt - d0, 0);
        exp_q.push_back(7);
        do_start(2, 2);
        send_pixel(3);
        send_pixel(7);
        send_pixel(-2);
        send_pixel(5);
        wait_drain("fresh_drain");
        check("fresh_done", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
